// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a commanded number of words from a show-ahead FIFO
// into a one-word registered valid/ready output slot, flagging the final word.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;
  state_t                r_state, w_next;
  logic [LEN_WIDTH-1:0]  r_rem;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid, r_out_last, r_done;
  logic                  w_cmd_hs, w_out_hs, w_pop, w_rem_one;
  assign w_cmd_hs   = cmd_valid && r_state == IDLE;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_rem_one  = r_rem == LEN_WIDTH'(1);
  // The slot may be refilled in the same cycle it drains, giving one word per cycle.
  assign w_pop      = r_state == BURST && !fifo_empty && (!r_out_valid || out_ready);
  assign cmd_ready  = r_state == IDLE;
  assign busy       = r_state != IDLE;
  assign fifo_rd_en = w_pop;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_last   = r_out_last;
  assign done       = r_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_cmd_hs && cmd_len != '0) w_next = BURST;
    if (r_state == BURST && w_pop && w_rem_one)       w_next = FLUSH;
    if (r_state == FLUSH && w_out_hs)                 w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= (w_cmd_hs && cmd_len == '0) || (r_state == FLUSH && w_out_hs);
      if (w_cmd_hs)   r_rem <= cmd_len;
      else if (w_pop) r_rem <= r_rem - LEN_WIDTH'(1);
      if (w_pop) begin
        r_out_data  <= fifo_rd_data;
        r_out_valid <= 1'b1;
        r_out_last  <= w_rem_one;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed and random bursts against a queue-based
// model of the FIFO, the output slot and the outstanding command.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int LW = 8;
  logic          clk = 1'b0, rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          fifo_rd_en, fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0, out_data;
  logic          out_valid, out_ready = 1'b0, out_last, busy, done;
  typedef struct packed {logic [DW-1:0] d; logic l;} word_t;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got[$];
  word_t         hold[$];
  bit            active, done_due;
  int            left, n_err, n_chk, done_seen, cmd_acc;
  always #5 clk = ~clk;
  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_rd_en && fifo_empty));
  a_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> $stable(out_data) && $stable(out_last));
  a_last_valid: assert property (@(posedge clk) disable iff (rst) out_last |-> out_valid);
  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask
  task automatic drive_fifo();
    fifo_empty   = q.size() == 0;
    fifo_rd_data = q.size() != 0 ? q[0] : 16'hDEAD;
  endtask
  task automatic step();
    bit pop, rd_exp, was_idle;
    drive_fifo();
    #1;
    was_idle = !active;
    rd_exp   = active && left > 0 && q.size() > 0 && (hold.size() == 0 || out_ready);
    chk("cmd_ready", 32'(cmd_ready), 32'(was_idle));
    chk("busy", 32'(busy), 32'(active));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(rd_exp));
    chk("out_valid", 32'(out_valid), 32'(hold.size() != 0));
    chk("out_last", 32'(out_last), hold.size() != 0 ? 32'(hold[0].l) : 32'd0);
    chk("done", 32'(done), 32'(done_due));
    if (hold.size() != 0) chk("out_data", 32'(out_data), 32'(hold[0].d));
    if (done) done_seen++;
    if (out_valid && out_ready) got.push_back(out_data);
    pop      = fifo_rd_en;
    done_due = 1'b0;
    if (hold.size() != 0 && out_ready) begin
      if (hold[0].l) begin
        active   = 1'b0;
        done_due = 1'b1;
      end
      void'(hold.pop_front());
    end
    if (rd_exp) begin
      hold.push_back(word_t'{q[0], left == 1});
      left--;
    end
    if (was_idle && cmd_valid) begin
      cmd_acc++;
      if (cmd_len == '0) done_due = 1'b1;
      else begin
        active = 1'b1;
        left   = int'(cmd_len);
      end
    end
    @(posedge clk);
    #1;
    if (pop && q.size() != 0) void'(q.pop_front());
    drive_fifo();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    if (active || done_due) cmd_acc--;
    active   = 1'b0;
    done_due = 1'b0;
    left     = 0;
    hold.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic start_cmd(input int len);
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    step();
    cmd_valid = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    // three-word burst at full rate
    q = '{16'h1111, 16'h2222, 16'h3333};
    got.delete();
    out_ready = 1'b1;
    start_cmd(3);
    repeat (6) step();
    chk("b3_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("b3_w0", 32'(got[0]), 32'h1111);
      chk("b3_w1", 32'(got[1]), 32'h2222);
      chk("b3_w2", 32'(got[2]), 32'h3333);
    end
    // zero-length command
    got.delete();
    start_cmd(0);
    repeat (3) step();
    chk("len0_words", 32'(got.size()), 32'd0);
    chk("len0_done", 32'(done_seen), 32'd2);
    // burst that starves the FIFO midway
    got.delete();
    q = '{16'hA001, 16'hA002};
    start_cmd(4);
    repeat (5) step();
    q.push_back(16'hA003);
    q.push_back(16'hA004);
    repeat (6) step();
    chk("stall_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) chk("stall_w3", 32'(got[3]), 32'hA004);
    // backpressure on the first word
    got.delete();
    q = '{16'hAAAA, 16'hBBBB};
    out_ready = 1'b0;
    start_cmd(2);
    repeat (4) step();
    out_ready = 1'b1;
    repeat (4) step();
    chk("bp_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      chk("bp_w0", 32'(got[0]), 32'hAAAA);
      chk("bp_w1", 32'(got[1]), 32'hBBBB);
    end
    // reset in the middle of a burst
    q = '{16'hC001, 16'hC002, 16'hC003, 16'hC004};
    out_ready = 1'b0;
    start_cmd(4);
    step();
    step();
    do_reset();
    out_ready = 1'b1;
    repeat (4) step();
    chk("rst_fifo_kept", 32'(q.size()), 32'd3);
    if (q.size() == 3) chk("rst_fifo_head", 32'(q[0]), 32'hC002);
    q.delete();
    // random traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid = $urandom_range(0, 3) == 0;
      cmd_len   = LW'($urandom_range(0, 5));
      out_ready = $urandom_range(0, 9) < 7;
      if (q.size() < 8 && $urandom_range(0, 1) == 1) q.push_back(DW'($urandom));
      if ($urandom_range(0, 249) == 0) do_reset();
      else step();
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) q.push_back(DW'($urandom));
    repeat (30) step();
    chk("drained_idle", 32'(busy), 32'd0);
    chk("done_per_cmd", 32'(done_seen), 32'(cmd_acc));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
